// File: rtl/definitions_main.sv
// Shared types and widths for the packet length meter.
package definitions_main;
    localparam int SIZE_W = 16;
    localparam int ACC_W  = 17;

    typedef enum logic {IDLE_METER, IN_PKT} states_meter;

    // Drop causes, kept for debug visibility in waveforms.
    typedef enum logic [1:0] {ERR_ORPHAN, ERR_ABORT, ERR_OVERSIZE} meter_err_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr together with inc loads STEP (start of a new sum).
module sat_counter #(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [W:0] STEP_X = (W+1)'(STEP);

    logic [W:0] sum;

    assign sum = {1'b0, (clr ? {W{1'b0}} : count)} + STEP_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= sum[W] ? {W{1'b1}} : sum[W-1:0];
        else if (clr)
            count <= '0;
    end
endmodule

// File: rtl/pkt_len_meter.sv
// Measures packet byte length on a word stream and emits one registered report per
// legal packet; orphan, aborted and oversize packets are dropped and counted.
module pkt_len_meter
    import definitions_main::*;
#(
    parameter int A_WIDTH        = 10,
    parameter int BYTES_PER_WORD = 8,
    parameter int MAX_SIZE       = 9600,
    localparam int EMPTY_W       = $clog2(BYTES_PER_WORD)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pkt_val_i,
    input  logic               pkt_sop_i,
    input  logic               pkt_eop_i,
    input  logic [EMPTY_W-1:0] pkt_empty_i,
    input  logic [A_WIDTH-1:0] pkt_flow_num_i,
    output logic [A_WIDTH-1:0] rx_flow_num_o,
    output logic [SIZE_W-1:0]  pkt_size_o,
    output logic               pkt_size_en_o,
    output logic               err_o,
    output logic [SIZE_W-1:0]  err_cnt_o
);
    typedef struct packed {
        logic [A_WIDTH-1:0] flow;
        logic [SIZE_W-1:0]  size;
    } MeterReport;

    localparam logic [ACC_W:0] MAX_X = (ACC_W+1)'(MAX_SIZE);
    localparam logic [ACC_W:0] BPW_X = (ACC_W+1)'(BYTES_PER_WORD);

    states_meter        state, state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [A_WIDTH-1:0] flow_q;
    logic               acc_clr, acc_inc, flow_ld;
    logic               rep_nxt, err_nxt;
    MeterReport         rep_d, rep_q;
    logic [ACC_W:0]     base, fin;

    // A sop beat always starts a fresh sum, even when it aborts a packet.
    assign base = (state == IN_PKT && !pkt_sop_i) ? {1'b0, acc} : '0;
    assign fin  = base + BPW_X - {{(ACC_W+1-EMPTY_W){1'b0}}, pkt_empty_i};

    always_comb begin
        state_nxt = state;
        if (pkt_val_i) begin
            if (pkt_sop_i)
                state_nxt = pkt_eop_i ? IDLE_METER : IN_PKT;
            else if (state == IN_PKT && pkt_eop_i)
                state_nxt = IDLE_METER;
        end
    end

    always_comb begin
        acc_clr = 1'b0;
        acc_inc = 1'b0;
        flow_ld = 1'b0;
        rep_nxt = 1'b0;
        err_nxt = 1'b0;
        rep_d   = '{flow: pkt_flow_num_i, size: fin[SIZE_W-1:0]};
        if (pkt_val_i) begin
            if (pkt_sop_i) begin
                err_nxt = (state == IN_PKT);
                if (pkt_eop_i) begin
                    rep_nxt = 1'b1;
                end else begin
                    acc_clr = 1'b1;
                    acc_inc = 1'b1;
                    flow_ld = 1'b1;
                end
            end else if (state == IDLE_METER) begin
                err_nxt = 1'b1;
            end else if (!pkt_eop_i) begin
                // Freeze once oversize; the eop check still sees a value > MAX_SIZE.
                acc_inc = ({1'b0, acc} <= MAX_X);
            end else begin
                rep_d.flow = flow_q;
                if (fin > MAX_X)
                    err_nxt = 1'b1;
                else
                    rep_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE_METER;
            flow_q        <= '0;
            rep_q         <= '0;
            pkt_size_en_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nxt;
            pkt_size_en_o <= rep_nxt;
            err_o         <= err_nxt;
            if (flow_ld)
                flow_q <= pkt_flow_num_i;
            if (rep_nxt)
                rep_q <= rep_d;
        end
    end

    assign rx_flow_num_o = rep_q.flow;
    assign pkt_size_o    = rep_q.size;

    sat_counter #(.W(ACC_W), .STEP(BYTES_PER_WORD)) u_acc (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (acc_clr),
        .inc   (acc_inc),
        .count (acc)
    );

    sat_counter #(.W(SIZE_W), .STEP(1)) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (err_nxt),
        .count (err_cnt_o)
    );
endmodule
